fsk_frame_ctrl: RTL and testbench

FSK_FRAME_CTRL -- requirements
Module: fsk_frame_ctrl

---
 rtl/fsk_pkg.sv | 26 ++
 rtl/fsk_baud_timer.sv | 34 +++
 rtl/fsk_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fsk_frame_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK frame controller.
//   state_t        : frame sequencer states (encoding is visible on state_o)
//   PRE_LEN_DEF    : default number of preamble symbols
//   SYNC_WORD_DEF  : default 8-bit sync pattern
//   DIV_W_DEF      : default baud divider width
//   PAY_W          : payload register width
//   clamp_len      : effective payload symbol count, min(len, PAY_W)
package fsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SYNC     = 2'd2,
    ST_PAYLOAD  = 2'd3
  } state_t;

  localparam int         PRE_LEN_DEF   = 8;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hD3;
  localparam int         DIV_W_DEF     = 16;
  localparam int         PAY_W         = 32;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

endpackage

// File: rtl/fsk_baud_timer.sv
// Baud divider: down-counter that sets the length of every symbol.
//   clk, reset : clock and synchronous active-high reset
//   load       : load cnt from div (first symbol of a frame)
//   enable     : count while a frame is being sent
//   div        : symbol period minus 1; also the reload value at symbol end
//   cnt        : current count, equals div on the first cycle of a symbol
//   sym_end    : high on the last cycle of each symbol (cnt == 0 while enabled)
module fsk_baud_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             sym_end
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (enable) begin
      // Reload at zero instead of wrapping, so each symbol is div+1 cycles.
      if (cnt == '0) cnt <= div;
      else           cnt <= cnt - DIV_W'(1);
    end
  end

  assign sym_end = enable && (cnt == '0);

endmodule

// File: rtl/fsk_frame_ctrl.sv
// FSK frame controller: sends preamble, sync word and payload as a symbol
// stream for an FSK modulator.
//   clk, reset  : clock and synchronous active-high reset
//   start/abort : frame request (IDLE only) / frame termination (abort wins)
//   payload, payload_len, baud_div : frame parameters captured on accepted start
//   busy, tx_en : frame in progress / modulator enable
//   tx_bit      : current symbol value
//   sym_strobe  : first cycle of each symbol
//   done        : one-cycle pulse in the first IDLE cycle after a complete frame
//   state_o     : FSM state for observation
module fsk_frame_ctrl
  import fsk_pkg::*;
#(
  parameter int         PRE_LEN   = PRE_LEN_DEF,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int         DIV_W     = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      payload,
  input  logic [5:0]       payload_len,
  input  logic [DIV_W-1:0] baud_div,
  output logic             busy,
  output logic             tx_en,
  output logic             tx_bit,
  output logic             sym_strobe,
  output logic             done,
  output logic [1:0]       state_o
);

  // Symbol counter must hold the longest phase (preamble or full payload).
  localparam int CNT_W = $clog2(((PRE_LEN > PAY_W) ? PRE_LEN : PAY_W) + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(7);

  state_t             state, state_nxt;
  logic [PAY_W-1:0]   shreg, shreg_nxt;
  logic [5:0]         len_r, len_nxt;
  logic [DIV_W-1:0]   div_r, div_nxt;
  logic [CNT_W-1:0]   sym_cnt, sym_cnt_nxt;
  logic               done_r, done_nxt;

  logic               t_load;
  logic               t_en;
  logic [DIV_W-1:0]   t_div;
  logic [DIV_W-1:0]   t_cnt;
  logic               sym_end;

  logic [5:0]         l_len;
  logic [CNT_W-1:0]   pay_last;
  logic [2:0]         sync_idx;

  assign l_len    = clamp_len(len_r);
  assign pay_last = CNT_W'(l_len) - CNT_W'(1);
  assign sync_idx = 3'd7 - sym_cnt[2:0];   // sync word goes out MSB first

  assign t_en  = (state != ST_IDLE);
  // On the accepting cycle the captured divider is not yet registered.
  assign t_div = t_load ? baud_div : div_r;

  fsk_baud_timer #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .load    (t_load),
    .enable  (t_en),
    .div     (t_div),
    .cnt     (t_cnt),
    .sym_end (sym_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      len_r   <= '0;
      div_r   <= '0;
      sym_cnt <= '0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      len_r   <= len_nxt;
      div_r   <= div_nxt;
      sym_cnt <= sym_cnt_nxt;
      done_r  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    len_nxt     = len_r;
    div_nxt     = div_r;
    sym_cnt_nxt = sym_cnt;
    done_nxt    = 1'b0;
    t_load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt   = ST_PREAMBLE;
          shreg_nxt   = payload;
          len_nxt     = payload_len;
          div_nxt     = baud_div;
          sym_cnt_nxt = '0;
          t_load      = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          state_nxt   = ST_IDLE;
          sym_cnt_nxt = '0;
        end else if (sym_end) begin
          case (state)
            ST_PREAMBLE: begin
              if (sym_cnt == PRE_LAST) begin
                state_nxt   = ST_SYNC;
                sym_cnt_nxt = '0;
              end else begin
                sym_cnt_nxt = sym_cnt + CNT_W'(1);
              end
            end
            ST_SYNC: begin
              if (sym_cnt == SYNC_LAST) begin
                sym_cnt_nxt = '0;
                if (l_len == 6'd0) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
                end else begin
                  state_nxt = ST_PAYLOAD;
                end
              end else begin
                sym_cnt_nxt = sym_cnt + CNT_W'(1);
              end
            end
            ST_PAYLOAD: begin
              shreg_nxt = shreg >> 1;   // next payload bit into bit 0
              if (sym_cnt == pay_last) begin
                state_nxt   = ST_IDLE;
                sym_cnt_nxt = '0;
                done_nxt    = 1'b1;
              end else begin
                sym_cnt_nxt = sym_cnt + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    tx_bit = 1'b0;
    case (state)
      ST_PREAMBLE: tx_bit = ~sym_cnt[0];
      ST_SYNC:     tx_bit = SYNC_WORD[sync_idx];
      ST_PAYLOAD:  tx_bit = shreg[0];
      default:     tx_bit = 1'b0;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign tx_en      = busy;
  // The counter sits at the captured divider only on a symbol's first cycle.
  assign sym_strobe = busy && (t_cnt == div_r);
  assign done       = done_r;
  assign state_o    = state;

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// Self-checking bench for fsk_frame_ctrl. Expected per-cycle outputs come
// from a symbol list built from the frame rules (preamble, sync, payload),
// each symbol stretched to baud_div+1 cycles.
module tb_fsk_frame_ctrl;

  localparam int PRE_LEN = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] payload;
  logic [5:0]  payload_len;
  logic [15:0] baud_div;
  logic        busy, tx_en, tx_bit, sym_strobe, done;
  logic [1:0]  state_o;

  logic [7:0]  sync_word = 8'hD3;
  int          errors = 0;
  int          checks = 0;

  fsk_frame_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .payload     (payload),
    .payload_len (payload_len),
    .baud_div    (baud_div),
    .busy        (busy),
    .tx_en       (tx_en),
    .tx_bit      (tx_bit),
    .sym_strobe  (sym_strobe),
    .done        (done),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Vector layout: {busy, tx_en, tx_bit, sym_strobe, done, state_o[1:0]}
  function automatic logic [6:0] obs_vec();
    return {busy, tx_en, tx_bit, sym_strobe, done, state_o};
  endfunction

  // Runs one frame starting from an IDLE cycle. kill_at >= 0 aborts (or resets)
  // at that frame cycle. Without a kill, returns in the done cycle.
  task automatic run_frame(input int div, input int len, input logic [31:0] pay,
                           input bit hold, input int kill_at, input bit kill_rst);
    bit         syms[$];
    int         l, total, sym, ph;
    logic [1:0] st;
    logic [6:0] e, o;
    l = (len > 32) ? 32 : len;
    for (int i = 0; i < PRE_LEN; i++) syms.push_back((i % 2) == 0);
    for (int i = 7; i >= 0; i--) syms.push_back(sync_word[i]);
    for (int i = 0; i < l; i++) syms.push_back(pay[i]);
    total = syms.size() * (div + 1);

    start = 1'b1; abort = 1'b0; payload = pay;
    payload_len = len[5:0]; baud_div = div[15:0];
    step();
    for (int c = 0; c < total; c++) begin
      sym = c / (div + 1);
      ph  = c % (div + 1);
      st  = (sym < PRE_LEN) ? 2'd1 : ((sym < PRE_LEN + 8) ? 2'd2 : 2'd3);
      e   = {1'b1, 1'b1, syms[sym], (ph == 0), 1'b0, st};
      o   = obs_vec();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL frame_cycle div=%0d len=%0d c=%0d got=%b exp=%b", div, len, c, o, e);
      end
      if (c == kill_at) begin
        if (kill_rst) begin
          reset = 1'b1; start = 1'b1;
          step();
          o = obs_vec(); checks++;
          if (o !== 7'b0) begin
            errors++; $display("FAIL reset_mid_frame got=%b exp=%b", o, 7'b0);
          end
          step();
          o = obs_vec(); checks++;
          if (o !== 7'b0) begin
            errors++; $display("FAIL reset_start_ignored got=%b exp=%b", o, 7'b0);
          end
          reset = 1'b0; start = 1'b0;
          step();
          o = obs_vec(); checks++;
          if (o !== 7'b0) begin
            errors++; $display("FAIL reset_no_done got=%b exp=%b", o, 7'b0);
          end
        end else begin
          abort = 1'b1; start = 1'b1;
          step();
          abort = 1'b0; start = 1'b0;
          o = obs_vec(); checks++;
          if (o !== 7'b0) begin
            errors++; $display("FAIL abort_next got=%b exp=%b", o, 7'b0);
          end
          step();
          o = obs_vec(); checks++;
          if (o !== 7'b0) begin
            errors++; $display("FAIL abort_no_done got=%b exp=%b", o, 7'b0);
          end
        end
        return;
      end
      // Inputs wander mid-frame; none of it may disturb the frame.
      start       = hold ? 1'b1 : 1'($urandom_range(0, 1));
      payload     = $urandom;
      payload_len = 6'($urandom_range(0, 63));
      baud_div    = 16'($urandom_range(0, 7));
      step();
    end
    o = obs_vec(); checks++;
    if (o !== 7'b0000100) begin
      errors++; $display("FAIL done_cycle div=%0d len=%0d got=%b exp=%b", div, len, o, 7'b0000100);
    end
    start = hold; abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    reset = 1'b1; start = 1'b1; abort = 1'b0;
    payload = $urandom; payload_len = 6'd8; baud_div = 16'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = obs_vec(); checks++;
      if (o !== 7'b0) begin
        errors++; $display("FAIL reset_state i=%0d got=%b exp=%b", i, o, 7'b0);
      end
    end
    reset = 1'b0; start = 1'b0;
    step();
    o = obs_vec(); checks++;
    if (o !== 7'b0) begin
      errors++; $display("FAIL reset_idle got=%b exp=%b", o, 7'b0);
    end
  endtask

  task automatic test_idle_after(input string name);
    logic [6:0] o;
    start = 1'b0;
    step();
    o = obs_vec(); checks++;
    if (o !== 7'b0) begin
      errors++; $display("FAIL %s got=%b exp=%b", name, o, 7'b0);
    end
  endtask

  task automatic test_nominal();
    run_frame(3, 4, 32'hA, 1'b0, -1, 1'b0);
    test_idle_after("nominal_done_once");
  endtask

  task automatic test_empty();
    run_frame(0, 0, $urandom, 1'b0, -1, 1'b0);
    test_idle_after("empty_idle");
  endtask

  task automatic test_clamp();
    run_frame(0, 40, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    test_idle_after("clamp_idle");
  endtask

  task automatic test_abort_idle();
    logic [6:0] o;
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    o = obs_vec(); checks++;
    if (o !== 7'b0) begin
      errors++; $display("FAIL abort_idle_priority got=%b exp=%b", o, 7'b0);
    end
  endtask

  task automatic test_abort();
    // div=1: cycle (PRE_LEN+2)*2+1 is the second cycle of the 3rd sync symbol.
    run_frame(1, 8, $urandom, 1'b0, (PRE_LEN + 2) * 2 + 1, 1'b0);
    run_frame(3, 4, 32'hA, 1'b0, -1, 1'b0);
    test_idle_after("after_abort_idle");
  endtask

  task automatic test_back_to_back();
    run_frame(2, 5, $urandom, 1'b1, -1, 1'b0);
    run_frame(1, 3, $urandom, 1'b1, -1, 1'b0);
    run_frame(0, 2, $urandom, 1'b0, -1, 1'b0);
    test_idle_after("b2b_end_idle");
  endtask

  task automatic test_reset_mid_payload();
    run_frame(1, 20, $urandom, 1'b0, (PRE_LEN + 8 + 3) * 2, 1'b1);
    run_frame(0, 6, $urandom, 1'b0, -1, 1'b0);
    test_idle_after("after_reset_idle");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_frame($urandom_range(0, 3), $urandom_range(0, 40), $urandom,
                1'($urandom_range(0, 1)), -1, 1'b0);
    end
    test_idle_after("random_end_idle");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_empty();
    test_clamp();
    test_abort_idle();
    test_abort();
    test_back_to_back();
    test_reset_mid_payload();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
